// File: rtl/program_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : program_sequencer_if
// Brief    : Instruction-memory and control-unit handshake bundle of the
//            program sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface program_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rd;
    logic [15:0]       imem_data;
    logic [15:0]       instr;
    logic              run;
    logic              cu_done;

    modport master (
        output imem_addr,
        output imem_rd,
        output instr,
        output run,
        input  imem_data,
        input  cu_done
    );

    modport slave (
        input  imem_addr,
        input  imem_rd,
        input  instr,
        input  run,
        output imem_data,
        output cu_done
    );
endinterface
`default_nettype wire

// File: rtl/program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : program_sequencer
// Brief    : Fetches instructions, dispatches ALU/immediate words to the control
//            unit, executes JUMP/HALT locally, with a done-timeout watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module program_sequencer #(
    parameter int ADDR_W       = 8,
    parameter int DONE_TIMEOUT = 8
) (
    input  wire                 clk,
    input  wire                 reset,
    input  wire                 start,
    input  wire                 halt_req,
    program_sequencer_if.master bus,
    output logic [ADDR_W-1:0]   pc,
    output logic [15:0]         instr_count,
    output logic                busy,
    output logic                halted,
    output logic                err
);
    localparam int                 c_TMO_W    = (DONE_TIMEOUT < 2) ? 1 : $clog2(DONE_TIMEOUT);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(DONE_TIMEOUT - 1);
    localparam logic [1:0]         c_OP_JUMP  = 2'b10;
    localparam logic [1:0]         c_OP_HALT  = 2'b11;

    typedef enum logic [2:0] {
        c_ST_IDLE   = 3'd0,
        c_ST_FETCH  = 3'd1,
        c_ST_LOAD   = 3'd2,
        c_ST_EXEC   = 3'd3,
        c_ST_HALTED = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [15:0]         r_instr;
    logic [15:0]         r_count;
    logic                r_err;
    logic                r_halt_pend;
    logic [c_TMO_W-1:0]  r_tmo;

    logic                w_busy;
    logic                w_halt_now;
    logic                w_start_ok;
    logic                w_jump;
    logic                w_retire;
    logic                w_timeout;
    logic [ADDR_W-1:0]   w_jump_target;

    assign w_busy        = (r_state == c_ST_FETCH) || (r_state == c_ST_LOAD) || (r_state == c_ST_EXEC);
    // A request raised in the exit cycle itself is honoured at that exit.
    assign w_halt_now    = r_halt_pend || halt_req;
    assign w_jump_target = ADDR_W'(bus.imem_data[12:5]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start_ok   = 1'b0;
        w_jump       = 1'b0;
        w_retire     = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            c_ST_IDLE, c_ST_HALTED: begin
                if (start) begin
                    w_start_ok   = 1'b1;
                    w_state_next = c_ST_FETCH;
                end
            end
            c_ST_FETCH: begin
                w_state_next = c_ST_LOAD;
            end
            c_ST_LOAD: begin
                // Decode the word arriving from memory, not the stale instr register.
                case (bus.imem_data[1:0])
                    c_OP_HALT: begin
                        w_state_next = c_ST_HALTED;
                    end
                    c_OP_JUMP: begin
                        w_jump       = 1'b1;
                        w_state_next = w_halt_now ? c_ST_HALTED : c_ST_FETCH;
                    end
                    default: begin
                        w_state_next = c_ST_EXEC;
                    end
                endcase
            end
            c_ST_EXEC: begin
                if (bus.cu_done) begin
                    w_retire     = 1'b1;
                    w_state_next = w_halt_now ? c_ST_HALTED : c_ST_FETCH;
                end else if (r_tmo == c_TMO_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = c_ST_HALTED;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= '0;
            r_instr     <= '0;
            r_count     <= '0;
            r_err       <= 1'b0;
            r_halt_pend <= 1'b0;
            r_tmo       <= '0;
        end else begin
            if (w_start_ok) begin
                r_pc        <= '0;
                r_count     <= '0;
                r_err       <= 1'b0;
                r_halt_pend <= 1'b0;
            end else if (w_busy && halt_req) begin
                r_halt_pend <= 1'b1;
            end

            if (r_state == c_ST_LOAD) begin
                r_instr <= bus.imem_data;
                r_tmo   <= '0;
            end

            if (r_state == c_ST_EXEC && !bus.cu_done) begin
                r_tmo <= r_tmo + 1'b1;
            end

            if (w_jump) begin
                r_pc <= w_jump_target;
            end

            if (w_retire) begin
                r_pc <= r_pc + 1'b1;
                if (r_count != 16'hFFFF) begin
                    r_count <= r_count + 16'd1;
                end
            end

            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.imem_addr = r_pc;
    assign bus.imem_rd   = (r_state == c_ST_FETCH);
    assign bus.instr     = r_instr;
    assign bus.run       = (r_state == c_ST_EXEC);

    assign pc          = r_pc;
    assign instr_count = r_count;
    assign busy        = w_busy;
    assign halted      = (r_state == c_ST_HALTED);
    assign err         = r_err;
endmodule
`default_nettype wire

// File: tb/tb_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_sequencer
// Brief    : Scoreboard bench: a program-level reference interpreter predicts
//            dispatches and the final halted state of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_sequencer;
    typedef struct {
        logic [7:0]  pc;
        logic [15:0] instr;
        int          lat;
    } disp_t;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] cnt;
        logic        err;
        int          elapsed;
    } fin_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        halt_req = 1'b0;
    logic [7:0]  pc;
    logic [15:0] instr_count;
    logic        busy;
    logic        halted;
    logic        err;

    logic [15:0] mem [0:255];
    disp_t       disp_q [$];
    fin_t        fin_q [$];
    int          lat_q [$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          start_cyc = 0;

    program_sequencer_if #(.ADDR_W(8)) bus ();

    program_sequencer #(.ADDR_W(8), .DONE_TIMEOUT(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .halt_req    (halt_req),
        .bus         (bus),
        .pc          (pc),
        .instr_count (instr_count),
        .busy        (busy),
        .halted      (halted),
        .err         (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bus.imem_rd) bus.imem_data <= mem[bus.imem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Control unit: raises done on run cycle N of a burst; N=0 never answers.
    initial begin
        int run_cnt = 0;
        int cur_lat = 0;
        bus.cu_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.run) begin
                run_cnt++;
                if (run_cnt == 1) cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
                bus.cu_done = (cur_lat != 0) && (run_cnt == cur_lat);
            end else begin
                run_cnt     = 0;
                bus.cu_done = 1'b0;
            end
        end
    end

    // Monitor: pops expectations as the DUT dispatches and halts.
    initial begin
        disp_t cur;
        fin_t  f;
        bit    have_cur = 0;
        bit    prev_run = 0;
        bit    prev_halted = 0;
        bit    moved = 0;
        int    burst = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                prev_run    = 0;
                prev_halted = 0;
            end else begin
                if (bus.run && !prev_run) begin
                    check("dispatch_expected", disp_q.size() > 0, 1);
                    have_cur = (disp_q.size() > 0);
                    if (have_cur) begin
                        cur = disp_q.pop_front();
                        check("dispatch_pc", pc, cur.pc);
                        check("dispatch_instr", bus.instr, cur.instr);
                    end
                    burst = 0;
                    moved = 0;
                end
                if (bus.run) begin
                    burst++;
                    if (have_cur && bus.instr !== cur.instr) moved = 1;
                end
                if (!bus.run && prev_run && have_cur) begin
                    check("run_burst_len", burst, (cur.lat == 0) ? 8 : cur.lat);
                    check("instr_stable", moved, 0);
                end
                if (halted) check("halted_strobes", {bus.run, bus.imem_rd}, 2'b00);
                if (halted && !prev_halted) begin
                    check("final_expected", fin_q.size() > 0, 1);
                    if (fin_q.size() > 0) begin
                        f = fin_q.pop_front();
                        check("final_pc", pc, f.pc);
                        check("final_count", instr_count, f.cnt);
                        check("final_err", err, f.err);
                        check("halt_latency", cyc - start_cyc - 1, f.elapsed);
                    end
                end
                prev_run    = bus.run;
                prev_halted = halted;
            end
        end
    end

    task automatic fill_halt();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0003;
    endtask

    // Leaves the caller at the falling edge of the first FETCH cycle.
    task automatic start_prog(input bit with_halt);
        @(negedge clk);
        start     = 1'b1;
        halt_req  = with_halt;
        start_cyc = cyc;
        @(negedge clk);
        start    = 1'b0;
        halt_req = 1'b0;
    endtask

    task automatic wait_halted(input string name);
        int n = 0;
        while (!halted && n < 600) begin
            @(negedge clk);
            n++;
        end
        check({name, "_reached_halt"}, halted, 1'b1);
        check({name, "_queues_drained"}, disp_q.size() + fin_q.size(), 0);
    endtask

    task automatic wait_run(input logic level, input string name);
        int n = 0;
        while (bus.run !== level && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, "_run_wait"}, bus.run, level);
    endtask

    task automatic expect_alu(input int p, input logic [15:0] w, input int lat);
        disp_q.push_back('{8'(p), w, lat});
        lat_q.push_back(lat);
    endtask

    // Reference interpreter: walks the program by opcode class and cycle cost.
    task automatic random_program(input int len);
        logic [15:0] w;
        int p = 0;
        int cnt = 0;
        int elapsed = 0;
        int lat;
        bit fin = 0;
        fill_halt();
        for (int i = 0; i < len; i++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                w[12:5] = 8'($urandom_range(i + 1, len));
                w[1:0]  = 2'b10;
            end else begin
                w[1:0] = 2'($urandom_range(0, 1));
            end
            mem[i] = w;
        end
        w = 16'($urandom);
        w[1:0] = 2'b11;
        mem[len] = w;
        while (!fin) begin
            w = mem[p];
            if (w[1:0] == 2'b11) begin
                elapsed += 2;
                fin = 1;
            end else if (w[1:0] == 2'b10) begin
                elapsed += 2;
                p = int'(w[12:5]);
            end else begin
                lat = $urandom_range(1, 6);
                expect_alu(p, w, lat);
                elapsed += 2 + lat;
                cnt++;
                p = (p + 1) % 256;
            end
        end
        fin_q.push_back('{8'(p), 16'(cnt), 1'b0, elapsed});
    endtask

    initial begin
        int c;
        int rd_n;
        fill_halt();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_pc", pc, 0);
        check("reset_count", instr_count, 0);
        check("reset_flags", {busy, halted, err}, 3'b000);
        check("reset_strobes", {bus.run, bus.imem_rd}, 2'b00);
        check("reset_instr", bus.instr, 0);

        // halt_req in IDLE is ignored
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        check("idle_ignores_halt", busy, 1'b0);

        // Straight-line program; start+halt_req together, stray start while busy
        mem[0] = 16'h2408; mem[1] = 16'h4810; mem[2] = 16'h0021; mem[3] = 16'h0003;
        expect_alu(0, 16'h2408, 4);
        expect_alu(1, 16'h4810, 4);
        expect_alu(2, 16'h0021, 4);
        fin_q.push_back('{8'd3, 16'd3, 1'b0, 20});
        start_prog(1'b1);
        repeat (7) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_halted("straight");

        // JUMP-to-self loop stopped by a one-cycle halt_req
        fill_halt();
        mem[0] = 16'h0002;
        c = $urandom_range(2, 9);
        fin_q.push_back('{8'd0, 16'd0, 1'b0, (c % 2 == 1) ? c + 1 : c + 2});
        start_prog(1'b0);
        rd_n = 0;
        for (int k = 0; k <= c + 2; k++) begin
            if (bus.imem_rd) rd_n++;
            halt_req = (k == c);
            @(negedge clk);
        end
        halt_req = 1'b0;
        check("jump_rd_pulses", rd_n, ((c % 2 == 1) ? c + 1 : c + 2) / 2);
        wait_halted("jump_loop");

        // halt_req in the 2nd run cycle waits for done
        fill_halt();
        mem[0] = 16'h2408; mem[1] = 16'h4810;
        expect_alu(0, 16'h2408, 4);
        fin_q.push_back('{8'd1, 16'd1, 1'b0, 6});
        start_prog(1'b0);
        wait_run(1'b1, "midexec");
        @(negedge clk);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        wait_halted("midexec_halt");

        // Done timeout, then restart clears err and fetches address 0
        fill_halt();
        mem[0] = 16'h2408;
        expect_alu(0, 16'h2408, 0);
        fin_q.push_back('{8'd0, 16'd0, 1'b1, 10});
        start_prog(1'b0);
        wait_halted("timeout");
        mem[0] = 16'h0003;
        fin_q.push_back('{8'd0, 16'd0, 1'b0, 2});
        start_prog(1'b0);
        check("restart_err_clear", err, 1'b0);
        check("restart_fetch", {bus.imem_rd, bus.imem_addr}, {1'b1, 8'd0});
        wait_halted("restart");

        // PC wrap from 255 to 0
        fill_halt();
        mem[0]   = 16'h1FE2;
        mem[255] = 16'h2408;
        mem[0]   = 16'h1FE2;
        expect_alu(255, 16'h2408, 3);
        fin_q.push_back('{8'd0, 16'd1, 1'b0, 9});
        start_prog(1'b0);
        wait_run(1'b1, "wrap");
        mem[0] = 16'h0003;
        wait_run(1'b0, "wrap_done");
        check("wrap_fetch", {bus.imem_rd, bus.imem_addr}, {1'b1, 8'd0});
        wait_halted("wrap");

        // Reset in the 3rd run cycle of the second instruction
        fill_halt();
        mem[0] = 16'h2408; mem[1] = 16'h4810;
        expect_alu(0, 16'h2408, 2);
        expect_alu(1, 16'h4810, 5);
        start_prog(1'b0);
        wait_run(1'b1, "rst_a");
        wait_run(1'b0, "rst_b");
        wait_run(1'b1, "rst_c");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("rst_run", bus.run, 1'b0);
        check("rst_pc", pc, 0);
        check("rst_instr", bus.instr, 0);
        check("rst_count", instr_count, 0);
        check("rst_flags", {busy, halted, err}, 3'b000);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_start_ignored", busy, 1'b0);
        check("rst_queues", disp_q.size() + lat_q.size(), 0);
        expect_alu(0, 16'h2408, 3);
        expect_alu(1, 16'h4810, 3);
        fin_q.push_back('{8'd2, 16'd2, 1'b0, 12});
        start_prog(1'b0);
        check("rst_refetch", {bus.imem_rd, bus.imem_addr}, {1'b1, 8'd0});
        wait_halted("after_reset");

        for (int t = 0; t < 8; t++) begin
            random_program($urandom_range(3, 14));
            start_prog(1'b0);
            wait_halted("random");
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete, got no finish, expected finish");
        $fatal(1, "global timeout");
    end
endmodule
`default_nettype wire
